pmem_arbiter: RTL and testbench
===============================

PMEM_ARBITER -- requirements
Module: pmem_arbiter

Interface
REQ-001 Parameter NUM_CONSUMERS, default 2, SHALL set the number of fetchers sharing one program-memory cache port.
REQ-002 Parameter ADDR_BITS, default 8, SHALL set the program address width.
REQ-003 Parameter DATA_BITS, default 16, SHALL set the instruction word width.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset  input  1  SHALL be an asynchronous, active-high reset.
REQ-006 consumer_read_valid  input  [NUM_CONSUMERS]  SHALL carry per-fetcher request flags.
REQ-007 consumer_read_address  input  [NUM_CONSUMERS] x ADDR_BITS  SHALL carry per-fetcher request addresses.
REQ-008 consumer_read_ready  output  [NUM_CONSUMERS]  SHALL carry per-fetcher response flags.
REQ-009 consumer_read_data  output  [NUM_CONSUMERS] x DATA_BITS  SHALL carry per-fetcher returned words.
REQ-010 cache_read_valid  output  1  SHALL be the request flag to the cache.
REQ-011 cache_read_address  output  ADDR_BITS  SHALL be the request address to the cache.
REQ-012 cache_read_ready  input  1  SHALL be the cache response flag.
REQ-013 cache_read_data  input  DATA_BITS  SHALL be the cache returned word.
REQ-014 grant_id  output  clog2(NUM_CONSUMERS), min 1  SHALL show the currently or last granted fetcher.
REQ-015 busy  output  1  SHALL be 1 whenever state is not IDLE.

Function
REQ-016 Handshake on both sides SHALL be four-phase: requester holds valid until ready seen, then drops valid; responder holds ready and data until valid drops, then drops ready.
REQ-017 The FSM SHALL have states IDLE, WAIT_CACHE, RELAY, DRAIN.
REQ-018 IDLE: if any consumer_read_valid is 1, select the first asserted index at or after rr_ptr (wrapping N-1 to 0), register grant_id, latch that address into cache_read_address, set cache_read_valid=1, go to WAIT_CACHE.
REQ-019 Grant-to-cache latency SHALL be exactly one edge after consumer valid is sampled.
REQ-020 WAIT_CACHE: on cache_read_ready=1, set cache_read_valid=0; if the granted valid is still 1, set consumer_read_ready[grant]=1 and consumer_read_data[grant]=cache_read_data and go to RELAY, else go to DRAIN.
REQ-021 RELAY: when consumer_read_valid[grant]=0, clear consumer_read_ready[grant] and consumer_read_data[grant] to 0 and go to DRAIN.
REQ-022 DRAIN: when cache_read_ready=0, set rr_ptr=(grant+1) mod NUM_CONSUMERS and go to IDLE; else stay.
REQ-023 Address changes from the granted consumer after the grant SHALL be ignored until the next grant.
REQ-024 Non-granted consumers SHALL see ready=0 and data=0 at all times; their requests stay pending.
REQ-025 Simultaneous requests SHALL be served in round-robin order; no consumer waits more than NUM_CONSUMERS-1 other transactions.
REQ-026 A granted consumer that drops valid during WAIT_CACHE (abandon) SHALL never receive ready; the returned word is discarded.
REQ-027 At most one outstanding cache transaction SHALL exist; cache_read_valid SHALL never re-assert before DRAIN completes.
REQ-028 rr_ptr SHALL advance only on DRAIN exit.

Reset
REQ-029 Reset assertion SHALL immediately force state=IDLE, rr_ptr=0, grant_id=0, cache_read_valid=0, cache_read_address=0, all consumer_read_ready=0, all consumer_read_data=0, independent of clk.
REQ-030 Reset mid-transaction SHALL abandon it; first post-reset grant goes to the lowest asserted index.

Structure
REQ-031 State enum (IDLE, WAIT_CACHE, RELAY, DRAIN) SHALL live in the shared package alongside the cache controller_state_t typedefs.
REQ-032 A sub-module rr_select (combinational request vector + pointer -> winner index, any flag) SHALL be used; the rest stays in pmem_arbiter.

Verification
REQ-033 Single request: consumer 0 valid, address 0x12; cache answers 0xBEEF two cycles later -> cache_read_valid 1 edge after request, consumer_read_ready[0]=1 with data 0xBEEF, cleared one edge after valid drops.
REQ-034 Simultaneous: both valid, addresses 0x03/0x40, rr_ptr=0 -> consumer 0 served first, consumer 1 second, grant_id 0 then 1.
REQ-035 Fairness: consumer 0 re-requests immediately after each completion with consumer 1 pending -> grants alternate 0,1,0,1 over four transactions.
REQ-036 Abandon: consumer 1 drops valid during WAIT_CACHE, cache returns 0x1234 -> consumer_read_ready[1] stays 0, FSM passes DRAIN to IDLE.
REQ-037 Slow cache release: cache holds ready 3 cycles after valid drops -> FSM stays in DRAIN, no new cache_read_valid until ready is 0.
REQ-038 Reset in RELAY: assert reset between edges -> all outputs 0 before next edge; after release, pending consumer 1 alone is granted.

Source files
------------

// File: rtl/pmem_arbiter_pkg.sv
// Shared types for the program-memory path.
//   arb_state_t        : pmem_arbiter FSM states
//   controller_state_t : program cache controller states
//   grant_bits()       : width of a consumer index (minimum 1 bit)
package pmem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_CACHE = 2'd1,
    RELAY      = 2'd2,
    DRAIN      = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    CTRL_IDLE    = 2'd0,
    CTRL_LOOKUP  = 2'd1,
    CTRL_FILL    = 2'd2,
    CTRL_RESPOND = 2'd3
  } controller_state_t;

  function automatic int grant_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pmem_arbiter_rr_select.sv
// Round-robin winner pick (purely combinational).
//   req    : request flags, one per consumer
//   ptr    : index with highest priority this round
//   winner : first asserted index at or after ptr, wrapping N-1 -> 0
//   any    : at least one request asserted
module pmem_arbiter_rr_select
  import pmem_arbiter_pkg::*;
#(
  parameter int N  = 2,
  parameter int GW = grant_bits(N)
) (
  input  logic [N-1:0]  req,
  input  logic [GW-1:0] ptr,
  output logic [GW-1:0] winner,
  output logic          any
);

  int idx;

  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = 0;
    for (int off = 0; off < N; off++) begin
      idx = (int'(ptr) + off) % N;
      if (!any && req[idx]) begin
        any    = 1'b1;
        winner = GW'(idx);
      end
    end
  end

endmodule

// File: rtl/pmem_arbiter.sv
// Shares one program-memory cache read port among NUM_CONSUMERS fetchers
// with round-robin priority and four-phase handshakes on both sides.
//   clk, reset                  : clock, async active-high reset
//   consumer_read_valid/address : per-fetcher requests
//   consumer_read_ready/data    : per-fetcher responses (0 unless granted)
//   cache_read_valid/address    : request to the cache
//   cache_read_ready/data       : response from the cache
//   grant_id                    : current or last granted fetcher
//   busy                        : FSM not in IDLE
//
// state      | meaning
// IDLE       | no transaction; pick next requester from rr_ptr
// WAIT_CACHE | request latched and presented to cache, awaiting ready
// RELAY      | word held on granted consumer until its valid drops
// DRAIN      | waiting for cache to drop ready; then advance rr_ptr
module pmem_arbiter
  import pmem_arbiter_pkg::*;
#(
  parameter int NUM_CONSUMERS = 2,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 16,
  localparam int GW           = grant_bits(NUM_CONSUMERS)
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [NUM_CONSUMERS-1:0]                consumer_read_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]                consumer_read_ready,
  output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data,
  output logic                                    cache_read_valid,
  output logic [ADDR_BITS-1:0]                    cache_read_address,
  input  logic                                    cache_read_ready,
  input  logic [DATA_BITS-1:0]                    cache_read_data,
  output logic [GW-1:0]                           grant_id,
  output logic                                    busy
);

  arb_state_t state, state_n;
  logic [GW-1:0] rr_ptr, rr_ptr_n, grant_n, winner;
  logic          any_req;
  logic          cache_valid_n;
  logic [ADDR_BITS-1:0] cache_addr_n;
  logic [NUM_CONSUMERS-1:0]                ready_n;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] data_n;

  pmem_arbiter_rr_select #(
    .N  (NUM_CONSUMERS),
    .GW (GW)
  ) u_rr_select (
    .req    (consumer_read_valid),
    .ptr    (rr_ptr),
    .winner (winner),
    .any    (any_req)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state               <= IDLE;
      rr_ptr              <= '0;
      grant_id            <= '0;
      cache_read_valid    <= 1'b0;
      cache_read_address  <= '0;
      consumer_read_ready <= '0;
      consumer_read_data  <= '0;
    end else begin
      state               <= state_n;
      rr_ptr              <= rr_ptr_n;
      grant_id            <= grant_n;
      cache_read_valid    <= cache_valid_n;
      cache_read_address  <= cache_addr_n;
      consumer_read_ready <= ready_n;
      consumer_read_data  <= data_n;
    end
  end

  always_comb begin
    state_n       = state;
    rr_ptr_n      = rr_ptr;
    grant_n       = grant_id;
    cache_valid_n = cache_read_valid;
    cache_addr_n  = cache_read_address;
    ready_n       = consumer_read_ready;
    data_n        = consumer_read_data;
    unique case (state)
      IDLE: begin
        if (any_req) begin
          grant_n       = winner;
          cache_addr_n  = consumer_read_address[winner];
          cache_valid_n = 1'b1;
          state_n       = WAIT_CACHE;
        end
      end
      WAIT_CACHE: begin
        if (cache_read_ready) begin
          cache_valid_n = 1'b0;
          // An abandoned request still completes on the cache side, but
          // its word is dropped and the fetcher never sees ready.
          if (consumer_read_valid[grant_id]) begin
            ready_n[grant_id] = 1'b1;
            data_n[grant_id]  = cache_read_data;
            state_n           = RELAY;
          end else begin
            state_n = DRAIN;
          end
        end
      end
      RELAY: begin
        if (!consumer_read_valid[grant_id]) begin
          ready_n = '0;
          data_n  = '0;
          state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (!cache_read_ready) begin
          rr_ptr_n = (grant_id == GW'(NUM_CONSUMERS - 1)) ? '0 : grant_id + GW'(1);
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_pmem_arbiter.sv
module tb_pmem_arbiter;

  logic             clk;
  logic             reset;
  logic [1:0]       consumer_read_valid;
  logic [1:0][7:0]  consumer_read_address;
  logic [1:0]       consumer_read_ready;
  logic [1:0][15:0] consumer_read_data;
  logic             cache_read_valid;
  logic [7:0]       cache_read_address;
  logic             cache_read_ready;
  logic [15:0]      cache_read_data;
  logic [0:0]       grant_id;
  logic             busy;

  int total = 0;
  int bad   = 0;

  // cache model knobs
  int          cache_lat  = 2;
  int          cache_hold = 0;
  logic [15:0] cache_word = 16'h0;

  pmem_arbiter #(
    .NUM_CONSUMERS (2),
    .ADDR_BITS     (8),
    .DATA_BITS     (16)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .consumer_read_valid   (consumer_read_valid),
    .consumer_read_address (consumer_read_address),
    .consumer_read_ready   (consumer_read_ready),
    .consumer_read_data    (consumer_read_data),
    .cache_read_valid      (cache_read_valid),
    .cache_read_address    (cache_read_address),
    .cache_read_ready      (cache_read_ready),
    .cache_read_data       (cache_read_data),
    .grant_id              (grant_id),
    .busy                  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Four-phase cache responder: ready cache_lat cycles after valid,
  // released cache_hold cycles after valid drops.
  initial begin
    int cst;
    int cnt;
    cst = 0;
    cnt = 0;
    cache_read_ready = 1'b0;
    cache_read_data  = 16'h0;
    forever begin
      @(posedge clk or posedge reset);
      #1;
      if (reset) begin
        cst = 0;
        cache_read_ready = 1'b0;
        cache_read_data  = 16'h0;
      end else begin
        case (cst)
          0: if (cache_read_valid) begin cnt = cache_lat; cst = 1; end
          1: begin
            if (cnt <= 1) begin
              cache_read_ready = 1'b1;
              cache_read_data  = cache_word;
              cst = 2;
            end else cnt--;
          end
          2: if (!cache_read_valid) begin
            if (cache_hold == 0) begin
              cache_read_ready = 1'b0;
              cache_read_data  = 16'h0;
              cst = 0;
            end else begin
              cnt = cache_hold;
              cst = 3;
            end
          end
          default: begin
            cnt--;
            if (cnt == 0) begin
              cache_read_ready = 1'b0;
              cache_read_data  = 16'h0;
              cst = 0;
            end
          end
        endcase
      end
    end
  end

  task automatic await_ready(output int who);
    logic found;
    found = 1'b0;
    who   = -1;
    for (int i = 0; i < 60; i++) begin
      if (consumer_read_ready != 2'b00) begin
        found = 1'b1;
        who   = consumer_read_ready[1] ? 1 : 0;
        break;
      end
      tick();
    end
    check("ready_seen", 32'(found), 32'd1);
  endtask

  task automatic await_idle();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (!busy && !cache_read_ready) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    check("idle_seen", 32'(done), 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    int who;
    int seq_ok;
    logic saw, bad_flag;
    logic [1:0] exp_order [4];
    reset = 1'b0;
    consumer_read_valid   = 2'b00;
    consumer_read_address = '0;
    #2;
    do_reset();

    // reset state
    check("rst_cvalid", 32'(cache_read_valid), 32'd0);
    check("rst_caddr",  32'(cache_read_address), 32'd0);
    check("rst_grant",  32'(grant_id), 32'd0);
    check("rst_busy",   32'(busy), 32'd0);
    check("rst_ready",  32'(consumer_read_ready), 32'd0);
    check("rst_data",   32'(consumer_read_data), 32'd0);

    // single request
    cache_lat  = 2;
    cache_hold = 0;
    cache_word = 16'hBEEF;
    consumer_read_address[0] = 8'h12;
    consumer_read_valid[0]   = 1'b1;
    tick();
    check("s1_cvalid", 32'(cache_read_valid), 32'd1);
    check("s1_caddr",  32'(cache_read_address), 32'h12);
    check("s1_grant",  32'(grant_id), 32'd0);
    check("s1_busy",   32'(busy), 32'd1);
    consumer_read_address[0] = 8'h55;
    await_ready(who);
    check("s1_who",    32'(who), 32'd0);
    check("s1_data0",  32'(consumer_read_data[0]), 32'hBEEF);
    check("s1_data1",  32'(consumer_read_data[1]), 32'd0);
    check("s1_caddr_held", 32'(cache_read_address), 32'h12);
    check("s1_cvalid_low", 32'(cache_read_valid), 32'd0);
    consumer_read_valid[0] = 1'b0;
    tick();
    check("s1_ready_clr", 32'(consumer_read_ready), 32'd0);
    check("s1_data_clr",  32'(consumer_read_data), 32'd0);
    await_idle();

    // simultaneous requests, rr_ptr back at 0
    do_reset();
    cache_word = 16'h1111;
    consumer_read_address[0] = 8'h03;
    consumer_read_address[1] = 8'h40;
    consumer_read_valid = 2'b11;
    tick();
    check("s2_grant0", 32'(grant_id), 32'd0);
    check("s2_caddr0", 32'(cache_read_address), 32'h03);
    await_ready(who);
    check("s2_who0",   32'(who), 32'd0);
    check("s2_data0",  32'(consumer_read_data[0]), 32'h1111);
    check("s2_nogrant_ready1", 32'(consumer_read_ready[1]), 32'd0);
    check("s2_nogrant_data1",  32'(consumer_read_data[1]), 32'd0);
    cache_word = 16'h2222;
    consumer_read_valid[0] = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (cache_read_valid) begin saw = 1'b1; break; end
    end
    check("s2_regrant", 32'(saw), 32'd1);
    check("s2_grant1",  32'(grant_id), 32'd1);
    check("s2_caddr1",  32'(cache_read_address), 32'h40);
    await_ready(who);
    check("s2_who1",    32'(who), 32'd1);
    check("s2_data1",   32'(consumer_read_data[1]), 32'h2222);
    check("s2_nogrant_data0", 32'(consumer_read_data[0]), 32'd0);
    consumer_read_valid[1] = 1'b0;
    tick();
    await_idle();

    // fairness: both keep re-requesting
    do_reset();
    exp_order[0] = 2'd0; exp_order[1] = 2'd1; exp_order[2] = 2'd0; exp_order[3] = 2'd1;
    seq_ok = 1;
    consumer_read_valid = 2'b11;
    for (int t = 0; t < 4; t++) begin
      cache_word = 16'hA000 + 16'(t);
      await_ready(who);
      if (who != int'(exp_order[t])) seq_ok = 0;
      check("s3_word", 32'(consumer_read_data[who[0]]), 32'hA000 + 32'(t));
      consumer_read_valid[who[0]] = 1'b0;
      tick();
      consumer_read_valid[who[0]] = 1'b1;
    end
    check("s3_order", 32'(seq_ok), 32'd1);
    consumer_read_valid = 2'b00;
    await_idle();
    tick();
    await_idle();

    // abandon during WAIT_CACHE
    do_reset();
    cache_lat  = 3;
    cache_word = 16'h1234;
    consumer_read_address[1] = 8'h77;
    consumer_read_valid[1] = 1'b1;
    tick();
    check("s4_grant", 32'(grant_id), 32'd1);
    consumer_read_valid[1] = 1'b0;
    saw = 1'b0;
    bad_flag = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (cache_read_ready) saw = 1'b1;
      if (consumer_read_ready != 2'b00) bad_flag = 1'b1;
    end
    check("s4_cache_answered", 32'(saw), 32'd1);
    check("s4_no_ready",       32'(bad_flag), 32'd0);
    check("s4_back_idle",      32'(busy), 32'd0);

    // slow cache release holds DRAIN
    do_reset();
    cache_lat  = 2;
    cache_hold = 3;
    cache_word = 16'h5A5A;
    consumer_read_address[0] = 8'h21;
    consumer_read_address[1] = 8'h22;
    consumer_read_valid = 2'b11;
    await_ready(who);
    check("s5_who", 32'(who), 32'd0);
    consumer_read_valid[0] = 1'b0;
    tick();
    bad_flag = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (!cache_read_ready) break;
      saw = 1'b1;
      if (cache_read_valid || !busy) bad_flag = 1'b1;
      tick();
    end
    check("s5_held",       32'(saw), 32'd1);
    check("s5_no_reissue", 32'(bad_flag), 32'd0);
    check("s5_release",    32'(cache_read_ready), 32'd0);
    saw = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (cache_read_valid) begin saw = 1'b1; break; end
    end
    check("s5_next_grant", 32'(saw), 32'd1);
    check("s5_grant1",     32'(grant_id), 32'd1);
    check("s5_caddr1",     32'(cache_read_address), 32'h22);
    await_ready(who);
    consumer_read_valid[1] = 1'b0;
    cache_hold = 0;
    tick();
    await_idle();

    // reset while in RELAY
    do_reset();
    cache_word = 16'hC0DE;
    consumer_read_address[0] = 8'h31;
    consumer_read_address[1] = 8'h32;
    consumer_read_valid = 2'b11;
    await_ready(who);
    check("s6_who", 32'(who), 32'd0);
    #2;
    reset = 1'b1;
    #1;
    check("s6_rst_ready",  32'(consumer_read_ready), 32'd0);
    check("s6_rst_data",   32'(consumer_read_data), 32'd0);
    check("s6_rst_cvalid", 32'(cache_read_valid), 32'd0);
    check("s6_rst_caddr",  32'(cache_read_address), 32'd0);
    check("s6_rst_grant",  32'(grant_id), 32'd0);
    check("s6_rst_busy",   32'(busy), 32'd0);
    consumer_read_valid[0] = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("s6_grant1",  32'(grant_id), 32'd1);
    check("s6_cvalid",  32'(cache_read_valid), 32'd1);
    check("s6_caddr1",  32'(cache_read_address), 32'h32);
    await_ready(who);
    check("s6_data1",   32'(consumer_read_data[1]), 32'hC0DE);
    consumer_read_valid[1] = 1'b0;
    tick();
    await_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
